cpu_seq_ctrl: RTL

//  Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.

---
 rtl/cpu_seq_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Memory reads use a req/ready handshake with a bounded wait before raising a bus error.
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_run,
  output logic             o_mem_req,
  input  logic             i_mem_ready,
  input  logic [7:0]       i_mem_rdata,
  output logic             o_pc_inc,
  output logic [7:0]       o_ir,
  output logic [7:0]       o_operand,
  output logic [3:0]       o_alu_op,
  output logic             o_acc_we,
  output logic             o_x_we,
  output logic             o_y_we,
  output logic             o_instr_done,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_halted,
  output logic             o_illegal_op,
  output logic             o_bus_err
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_HALT, S_ERROR
  } state_t;
  state_t           r_state, w_next;
  logic [WW-1:0]    r_wait;
  logic [7:0]       r_ir, r_operand;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal, r_bus_err;
  logic             w_req, w_acc, w_tmo, w_two, w_one, w_hlt, w_exec;
  assign w_req  = (r_state == S_FETCH) || (r_state == S_OPERAND);
  assign w_acc  = w_req & i_mem_ready;
  // timeout fires on the edge that would complete the MEM_TIMEOUT-th wait cycle
  assign w_tmo  = w_req & ~i_mem_ready & (r_wait == WW'(MEM_TIMEOUT - 1));
  assign w_two  = r_ir inside {8'h01, 8'h06, 8'h09, 8'h10, 8'h12, 8'h20, 8'h22, 8'h24};
  assign w_one  = r_ir inside {8'h00, 8'h26, 8'h16, 8'h17};
  assign w_hlt  = r_ir == 8'hff;
  assign w_exec = r_state == S_EXEC;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = i_run ? S_FETCH : S_IDLE;
      S_FETCH:   w_next = w_acc ? S_DECODE : w_tmo ? S_ERROR : S_FETCH;
      S_DECODE:  w_next = w_two ? S_OPERAND : w_one ? S_EXEC : w_hlt ? S_HALT : S_ERROR;
      S_OPERAND: w_next = w_acc ? S_EXEC : w_tmo ? S_ERROR : S_OPERAND;
      S_EXEC:    w_next = i_run ? S_FETCH : S_IDLE;
      default:   w_next = r_state;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wait    <= '0;
      r_ir      <= '0;
      r_operand <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_wait <= (w_req & ~i_mem_ready) ? r_wait + 1'b1 : '0;
      if (r_state == S_FETCH && w_acc) r_ir <= i_mem_rdata;
      if (r_state == S_OPERAND && w_acc) r_operand <= i_mem_rdata;
      if (r_state == S_DECODE && w_one) r_operand <= '0;
      if (r_state == S_DECODE && !w_two && !w_one && !w_hlt) r_illegal <= 1'b1;
      if (w_tmo) r_bus_err <= 1'b1;
      if (w_exec) r_count <= r_count + 1'b1;
    end
  end
  always_comb begin
    o_alu_op = 4'hf;
    o_acc_we = 1'b0;
    o_x_we   = 1'b0;
    o_y_we   = 1'b0;
    if (w_exec) begin
      case (r_ir)
        8'h01: begin o_alu_op = 4'h0; o_acc_we = 1'b1; end
        8'h06: o_x_we = 1'b1;
        8'h09: o_y_we = 1'b1;
        8'h10: begin o_alu_op = 4'h1; o_acc_we = 1'b1; end
        8'h12: begin o_alu_op = 4'h2; o_acc_we = 1'b1; end
        8'h20: begin o_alu_op = 4'h3; o_acc_we = 1'b1; end
        8'h22: begin o_alu_op = 4'h4; o_acc_we = 1'b1; end
        8'h24: begin o_alu_op = 4'h5; o_acc_we = 1'b1; end
        8'h26: begin o_alu_op = 4'h6; o_acc_we = 1'b1; end
        8'h16: begin o_alu_op = 4'h7; o_acc_we = 1'b1; end
        8'h17: begin o_alu_op = 4'h8; o_acc_we = 1'b1; end
        default: ;
      endcase
    end
  end
  assign o_mem_req     = w_req;
  assign o_pc_inc      = w_acc;
  assign o_ir          = r_ir;
  assign o_operand     = r_operand;
  assign o_instr_done  = w_exec;
  assign o_instr_count = r_count;
  assign o_halted      = r_state == S_HALT;
  assign o_illegal_op  = r_illegal;
  assign o_bus_err     = r_bus_err;
endmodule
